// File: rtl/display_scan4.sv
// Four-digit multiplexed display scanner with shadow/active value registers.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits 3..1).
module display_scan4 #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] D,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [3:0]  A,
  output logic [3:0]  Dig,
  output logic        H,
  output logic        frame
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic          run_q, run_d;
  logic [15:0]   shadow_q, shadow_d, active_q, active_d;
  logic [3:0]    shdp_q, shdp_d, actdp_q, actdp_d;
  logic [3:0]    a_q, a_d, dig_q, dig_d;
  logic          h_q, h_d, frame_q, frame_d;
  logic          wrap, off;

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic blank_f(input logic [15:0] v, input logic [1:0] i);
    case (i)
      2'd0:    blank_f = 1'b0;
      2'd1:    blank_f = (v[15:4] == 12'h000);
      2'd2:    blank_f = (v[15:8] == 8'h00);
      default: blank_f = (v[15:12] == 4'h0);
    endcase
  endfunction
`endif

  always_comb begin
    presc_d  = presc_q;
    idx_d    = idx_q;
    run_d    = 1'b1;
    wrap     = 1'b0;
    frame_d  = 1'b0;
    // The first edge after reset opens slot 0 and also loads the active
    // register, but is not reported as a frame boundary.
    if (!run_q) begin
      presc_d = '0;
      idx_d   = 2'd0;
      wrap    = 1'b1;
    end else if (presc_q == PMAX) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
      wrap    = (idx_q == 2'd3);
      frame_d = (idx_q == 2'd3);
    end else begin
      presc_d = presc_q + 1'b1;
    end

    shadow_d = load ? D : shadow_q;
    shdp_d   = load ? dp_in : shdp_q;
    active_d = active_q;
    actdp_d  = actdp_q;
    if (wrap) begin
      active_d = load ? D : shadow_q;
      actdp_d  = load ? dp_in : shdp_q;
    end

    // Outputs are computed from next state so they line up with the registered slot.
    a_d = active_d[{idx_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    off = (presc_d == '0) || blank_f(active_d, idx_d);
`else
    off = (presc_d == '0);
`endif
    dig_d = off ? 4'b1111 : ~(4'b0001 << idx_d);
    h_d   = off ? 1'b1 : ~actdp_d[idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      idx_q    <= 2'd0;
      run_q    <= 1'b0;
      shadow_q <= '0;
      shdp_q   <= '0;
      active_q <= '0;
      actdp_q  <= '0;
      a_q      <= '0;
      dig_q    <= 4'b1111;
      h_q      <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      run_q    <= run_d;
      shadow_q <= shadow_d;
      shdp_q   <= shdp_d;
      active_q <= active_d;
      actdp_q  <= actdp_d;
      a_q      <= a_d;
      dig_q    <= dig_d;
      h_q      <= h_d;
      frame_q  <= frame_d;
    end
  end

  assign A     = a_q;
  assign Dig   = dig_q;
  assign H     = h_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_display_scan4.sv
// Directed + random bench for display_scan4 against a cycle-count based model.
module tb_display_scan4;
  localparam int P = 4;
  localparam int FR = 4 * P;

  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0;
  logic [15:0] D = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  A, Dig;
  logic        H, frame;

  display_scan4 #(.PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .D(D), .dp_in(dp_in), .load(load),
    .A(A), .Dig(Dig), .H(H), .frame(frame)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int k = 0;  // edges seen since reset release
  logic [15:0] m_sh = '0, m_act = '0;
  logic [3:0]  m_shdp = '0, m_actdp = '0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".A"}, 16'(A), 16'h0);
    chk({tag, ".Dig"}, 16'(Dig), 16'hf);
    chk({tag, ".H"}, 16'(H), 16'h1);
    chk({tag, ".frame"}, 16'(frame), 16'h0);
  endtask

  // One clock: update the model from the inputs seen at the edge, then check.
  task automatic step();
    int p, idx, pr;
    logic off;
    logic [3:0] e_dig;
    logic e_h;
    @(posedge clk);
    p = k;
    if (p % FR == 0) begin
      m_act   = load ? D : m_sh;
      m_actdp = load ? dp_in : m_shdp;
    end
    if (load) begin
      m_sh   = D;
      m_shdp = dp_in;
    end
    k++;
    idx = (p / P) % 4;
    pr  = p % P;
    off = (pr == 0);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (m_act >> (4 * idx)) == 16'h0) off = 1'b1;
`endif
    e_dig = off ? 4'hf : ~(4'b0001 << idx);
    e_h   = off ? 1'b1 : ~m_actdp[idx];
    @(negedge clk);
    chk("A", 16'(A), (m_act >> (4 * idx)) & 16'hf);
    chk("Dig", 16'(Dig), 16'(e_dig));
    chk("H", 16'(H), 16'(e_h));
    chk("frame", 16'(frame), 16'((p % FR == 0) && (p > 0)));
  endtask

  // Step with load low until the next edge falls at the given frame phase.
  task automatic run_to(input int phase);
    load = 1'b0;
    while (k % FR != phase) step();
  endtask

  task automatic load_step(input logic [15:0] d, input logic [3:0] dp);
    D = d; dp_in = dp; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst_hold");
    rst_n = 1'b1;

    // First cycle load shows in the first frame.
    load_step(16'h1234, 4'b0000);
    repeat (2 * FR) step();

    // Load mid-frame at slot idx1: takes effect next frame.
    run_to(5);
    load_step(16'hABCD, 4'b0000);
    repeat (2 * FR + 3) step();

    // Load exactly on the frame-wrap edge.
    run_to(0);
    load_step(16'h5555, 4'b0000);
    repeat (FR) step();

    // Decimal point on digit 2.
    run_to(7);
    load_step(16'h9876, 4'b0100);
    repeat (2 * FR) step();

    // Leading zero patterns.
    run_to(3);
    load_step(16'h0005, 4'b0000);
    repeat (2 * FR) step();
    run_to(3);
    load_step(16'h0000, 4'b0001);
    repeat (2 * FR) step();
    run_to(3);
    load_step(16'h0050, 4'b1000);
    repeat (2 * FR) step();

    // Random loads.
    for (int i = 0; i < 400; i++) begin
      D     = 16'($urandom);
      if ($urandom_range(0, 3) == 0) D[15:8] = 8'h00;
      dp_in = 4'($urandom);
      load  = ($urandom_range(0, 5) == 0);
      step();
    end
    load = 1'b0;

    // Asynchronous reset in the middle of slot idx2.
    while (!(((k - 1) / P) % 4 == 2 && (k - 1) % P == 1)) step();
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_async");
    @(posedge clk);
    @(negedge clk);
    chk_reset("rst_held");
    rst_n = 1'b1;
    k = 0; m_sh = '0; m_act = '0; m_shdp = '0; m_actdp = '0;
    repeat (2 * FR) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
